// File: rtl/apb3_regfile_slave.sv
`default_nettype none
// ============================================================================
// Module      : apb3_regfile_slave
// Description : APB3 slave endpoint that terminates the bus in a bank of
//               NUM_REGS registers. Provides programmable wait states,
//               error responses (range, alignment, read-only write, protocol
//               violation) and one-cycle write/read strobes for downstream
//               logic.
// Revision    : 1.0 - initial release
// ============================================================================
module apb3_regfile_slave #(
    parameter int                    ADDR_WIDTH  = 12,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 8,
    parameter int                    WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic                           pclk,
    input  logic                           rst,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pready,
    output logic                           pslverr,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_q,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_rdata,
    output logic                           wr_stb,
    output logic                           rd_stb,
    output logic [7:0]                     stb_idx
);

    // Byte-lane address bits below the word index
    localparam int          c_al    = $clog2(DATA_WIDTH / 8);
    localparam int          c_iw    = ADDR_WIDTH - c_al;
    localparam logic [3:0]  c_wait  = 4'(WAIT_STATES);
    localparam logic [31:0] c_num   = 32'(NUM_REGS);

    localparam logic [1:0]  c_st_idle   = 2'd0;
    localparam logic [1:0]  c_st_setup  = 2'd1;
    localparam logic [1:0]  c_st_access = 2'd2;

    logic [1:0]            r_state;
    logic [3:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic [c_iw-1:0]       w_idx;
    logic                  w_misalign;
    logic                  w_range_err;
    logic                  w_ro_hit;
    logic                  w_req_err;
    logic                  w_acc_rdy;
    logic                  w_viol;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [DATA_WIDTH-1:0] w_rd_sel;

    // All decode works on the request copy captured in SETUP, never on the live bus
    assign w_idx = r_addr[ADDR_WIDTH-1:c_al];

    generate
        if (c_al > 0) begin : g_align
            assign w_misalign = |r_addr[c_al-1:0];
        end else begin : g_no_align
            assign w_misalign = 1'b0;
        end
    endgenerate

    assign w_range_err = (32'(w_idx) >= c_num);

    // Read-data mux and read-only lookup for the latched index
    always_comb begin
        w_rd_sel = '0;
        w_ro_hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (32'(w_idx) == 32'(i)) begin
                w_rd_sel = regs_q[i*DATA_WIDTH +: DATA_WIDTH];
                w_ro_hit = RO_MASK[i];
            end
        end
    end

    assign w_req_err = w_range_err | w_misalign | (r_write & w_ro_hit);

    // psel is part of completion so a dropped select can never commit a write
    assign w_acc_rdy = (r_state == c_st_access) & psel & penable & (r_cnt == c_wait);
    // Access phase seen without a preceding setup; suppressed while in reset
    assign w_viol    = (r_state == c_st_idle) & psel & penable & ~rst;

    assign w_wr_en   = w_acc_rdy &  r_write & ~w_req_err;
    assign w_rd_en   = w_acc_rdy & ~r_write & ~w_req_err;

    assign pready    = w_acc_rdy | w_viol;
    assign pslverr   = w_viol | (w_acc_rdy & w_req_err);
    assign prdata    = w_rd_en ? w_rd_sel : '0;
    assign wr_stb    = w_wr_en;
    assign rd_stb    = w_rd_en;
    assign stb_idx   = (w_wr_en | w_rd_en) ? 8'(w_idx) : 8'd0;

    // Transfer FSM: request capture in SETUP, wait-state counting in ACCESS
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (psel && !penable) begin
                        r_state <= c_st_setup;
                    end
                end
                c_st_setup: begin
                    r_addr  <= paddr;
                    r_write <= pwrite;
                    r_wdata <= pwdata;
                    r_cnt   <= 4'd0;
                    r_state <= c_st_access;
                end
                c_st_access: begin
                    if (!psel || w_acc_rdy) begin
                        r_state <= c_st_idle;
                    end else if (r_cnt < c_wait) begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Register bank: read-only slots mirror hardware, writable slots hold state
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (RO_MASK[gi]) begin : g_ro
                assign regs_q[gi*DATA_WIDTH +: DATA_WIDTH] = hw_rdata[gi*DATA_WIDTH +: DATA_WIDTH];
            end else begin : g_rw
                logic [DATA_WIDTH-1:0] r_q;
                logic                  w_hw_unused;

                // Hardware value is only meaningful for read-only slots
                assign w_hw_unused = ^hw_rdata[gi*DATA_WIDTH +: DATA_WIDTH];

                // Commit the latched write data on a successful write completion
                always_ff @(posedge pclk or posedge rst) begin
                    if (rst) begin
                        r_q <= RESET_VAL;
                    end else if (w_wr_en && (32'(w_idx) == 32'(gi))) begin
                        r_q <= r_wdata;
                    end
                end

                assign regs_q[gi*DATA_WIDTH +: DATA_WIDTH] = r_q;
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_apb3_regfile_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb3_regfile_slave
// Description : Self-checking bench for apb3_regfile_slave. Two instances:
//               u_dut0 (no wait states, register 7 read-only) and
//               u_dut1 (three wait states, all writable).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb3_regfile_slave;

    localparam int c_w0 = 0;
    localparam int c_w1 = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [11:0] paddr   [2];
    logic [31:0] pwdata  [2];
    logic [31:0] prdata  [2];
    logic        pready  [2];
    logic        pslverr [2];
    logic        wr_stb  [2];
    logic        rd_stb  [2];
    logic [7:0]  stb_idx [2];
    logic [255:0] regs_q [2];
    logic [255:0] hw     [2];

    int errors = 0;
    int checks = 0;
    int wr_cnt [2];
    int rd_cnt [2];
    logic [31:0] mdl [2][8];

    typedef struct {
        int          k;
        logic [11:0] a;
        logic        w;
        logic [31:0] d;
        logic [31:0] er;
        logic        ee;
    } vec_t;

    vec_t tbl [14];

    always #5 clk = ~clk;

    apb3_regfile_slave #(
        .ADDR_WIDTH(12), .DATA_WIDTH(32), .NUM_REGS(8),
        .WAIT_STATES(c_w0), .RO_MASK(8'h80), .RESET_VAL(32'h0)
    ) u_dut0 (
        .pclk(clk), .rst(rst), .psel(psel[0]), .penable(penable[0]),
        .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]),
        .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]),
        .regs_q(regs_q[0]), .hw_rdata(hw[0]), .wr_stb(wr_stb[0]),
        .rd_stb(rd_stb[0]), .stb_idx(stb_idx[0])
    );

    apb3_regfile_slave #(
        .ADDR_WIDTH(12), .DATA_WIDTH(32), .NUM_REGS(8),
        .WAIT_STATES(c_w1), .RO_MASK(8'h00), .RESET_VAL(32'h0)
    ) u_dut1 (
        .pclk(clk), .rst(rst), .psel(psel[1]), .penable(penable[1]),
        .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]),
        .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]),
        .regs_q(regs_q[1]), .hw_rdata(hw[1]), .wr_stb(wr_stb[1]),
        .rd_stb(rd_stb[1]), .stb_idx(stb_idx[1])
    );

    // Strobe pulse counters
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            wr_cnt[k] += int'(wr_stb[k]);
            rd_cnt[k] += int'(rd_stb[k]);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int waits_of(input int k);
        return (k == 0) ? c_w0 : c_w1;
    endfunction

    // Reference behaviour derived from the address/error rules
    function automatic void model_exp(input int k, input logic [11:0] a, input logic w,
                                      output logic [31:0] er, output logic ee);
        int   idx;
        logic ro;
        idx = int'(a) / 4;
        ro  = (k == 0) && (idx == 7);
        ee  = (idx >= 8) || ((int'(a) % 4) != 0) || (w && ro);
        er  = 32'h0;
        if (!ee && !w) er = ro ? hw[k][7*32 +: 32] : mdl[k][idx];
    endfunction

    // One APB transfer; entered and left just after a rising edge
    task automatic xfer(input int k, input logic [11:0] a, input logic w, input logic [31:0] d,
                        output logic [31:0] rd, output logic err, output logic [7:0] si,
                        output int nlow, output logic done);
        psel[k] = 1'b1; penable[k] = 1'b0; paddr[k] = a; pwrite[k] = w; pwdata[k] = d;
        @(posedge clk); #1;
        penable[k] = 1'b1;
        nlow = 0; done = 1'b0; rd = '0; err = 1'b0; si = '0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (pready[k]) begin
                done = 1'b1;
                rd   = prdata[k];
                err  = pslverr[k];
                si   = stb_idx[k];
            end else begin
                nlow++;
            end
            @(posedge clk); #1;
        end
        psel[k] = 1'b0; penable[k] = 1'b0;
    endtask

    task automatic do_txn(input string name, input int k, input logic [11:0] a, input logic w,
                          input logic [31:0] d, input logic [31:0] er, input logic ee);
        logic [31:0] rd;
        logic        err;
        logic        done;
        logic [7:0]  si;
        int          nlow;
        int          w0;
        int          r0;
        w0 = wr_cnt[k];
        r0 = rd_cnt[k];
        xfer(k, a, w, d, rd, err, si, nlow, done);
        chk({name, " done"}, 32'(done), 32'd1);
        chk({name, " pslverr"}, 32'(err), 32'(ee));
        if (!w) chk({name, " prdata"}, rd, er);
        // One extra low cycle for the SETUP state ahead of the access cycles
        chk({name, " wait"}, 32'(nlow), 32'(waits_of(k) + 1));
        chk({name, " wr_stb"}, 32'(wr_cnt[k] - w0), (w && !ee) ? 32'd1 : 32'd0);
        chk({name, " rd_stb"}, 32'(rd_cnt[k] - r0), (!w && !ee) ? 32'd1 : 32'd0);
        chk({name, " stb_idx"}, 32'(si), ee ? 32'd0 : 32'(a >> 2));
        if (w && !ee) mdl[k][a[4:2]] = d;
    endtask

    task automatic reset_model();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 8; i++)
                mdl[k][i] = 32'h0;
    endtask

    initial begin
        logic [31:0] er;
        logic        ee;
        logic [11:0] a;
        logic        w;
        logic [31:0] d;
        int          k;
        int          w0;

        tbl[0]  = '{0, 12'h004, 1'b1, 32'hDEADBEEF, 32'h0,        1'b0};
        tbl[1]  = '{0, 12'h004, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2]  = '{0, 12'h020, 1'b1, 32'h11111111, 32'h0,        1'b1};
        tbl[3]  = '{0, 12'h002, 1'b1, 32'h22222222, 32'h0,        1'b1};
        tbl[4]  = '{0, 12'h01C, 1'b1, 32'h33333333, 32'h0,        1'b1};
        tbl[5]  = '{0, 12'h01C, 1'b0, 32'h0,        32'h12345678, 1'b0};
        tbl[6]  = '{0, 12'h000, 1'b0, 32'h0,        32'h00000000, 1'b0};
        tbl[7]  = '{0, 12'h020, 1'b0, 32'h0,        32'h00000000, 1'b1};
        tbl[8]  = '{0, 12'h006, 1'b0, 32'h0,        32'h00000000, 1'b1};
        tbl[9]  = '{1, 12'h000, 1'b0, 32'h0,        32'h00000000, 1'b0};
        tbl[10] = '{1, 12'h01C, 1'b1, 32'hCAFEF00D, 32'h0,        1'b0};
        tbl[11] = '{1, 12'h01C, 1'b0, 32'h0,        32'hCAFEF00D, 1'b0};
        tbl[12] = '{1, 12'h3FC, 1'b1, 32'h00000001, 32'h0,        1'b1};
        tbl[13] = '{0, 12'h004, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0};

        for (int i = 0; i < 8; i++) begin
            hw[0][i*32 +: 32] = (i == 7) ? 32'h12345678 : (32'hA0000000 | 32'(i));
            hw[1][i*32 +: 32] = 32'h5555AAAA ^ 32'(i);
        end
        for (int j = 0; j < 2; j++) begin
            psel[j] = 1'b0; penable[j] = 1'b0; pwrite[j] = 1'b0;
            paddr[j] = '0; pwdata[j] = '0; wr_cnt[j] = 0; rd_cnt[j] = 0;
        end
        reset_model();

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            chk("reset pready", 32'(pready[j]), 32'd0);
            chk("reset pslverr", 32'(pslverr[j]), 32'd0);
            chk("reset prdata", prdata[j], 32'd0);
            chk("reset stb_idx", 32'(stb_idx[j]), 32'd0);
            chk("reset reg0", regs_q[j][31:0], 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 14; i++)
            do_txn($sformatf("tbl%0d", i), tbl[i].k, tbl[i].a, tbl[i].w, tbl[i].d, tbl[i].er, tbl[i].ee);
        for (int i = 0; i < 7; i++)
            chk($sformatf("bank0 reg%0d", i), regs_q[0][i*32 +: 32], mdl[0][i]);
        for (int i = 0; i < 8; i++)
            chk($sformatf("bank1 reg%0d", i), regs_q[1][i*32 +: 32], mdl[1][i]);

        // Protocol violation: access phase with no setup
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1;
        paddr[0] = 12'h000; pwdata[0] = 32'hBAD0BAD0;
        @(negedge clk);
        chk("viol pready", 32'(pready[0]), 32'd1);
        chk("viol pslverr", 32'(pslverr[0]), 32'd1);
        chk("viol wr_stb", 32'(wr_stb[0]), 32'd0);
        chk("viol prdata", prdata[0], 32'd0);
        @(posedge clk); #1;
        psel[0] = 1'b0; penable[0] = 1'b0;
        @(posedge clk); #1;
        chk("viol no write", regs_q[0][31:0], mdl[0][0]);

        // psel dropped during wait states
        w0 = wr_cnt[1];
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 12'h00C; pwdata[1] = 32'h77777777;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        psel[1] = 1'b0; penable[1] = 1'b0;
        @(negedge clk);
        chk("drop pready", 32'(pready[1]), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("drop no write", regs_q[1][3*32 +: 32], mdl[1][3]);
        chk("drop no strobe", 32'(wr_cnt[1] - w0), 32'd0);
        model_exp(1, 12'h00C, 1'b0, er, ee);
        do_txn("after drop", 1, 12'h00C, 1'b0, 32'h0, er, ee);

        // Reset in the second wait cycle of a write
        do_txn("pre-reset wr", 1, 12'h008, 1'b1, 32'h5A5A0001, 32'h0, 1'b0);
        w0 = wr_cnt[1];
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 12'h008; pwdata[1] = 32'hA5A5A5A5;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst pready", 32'(pready[1]), 32'd0);
        chk("rst pslverr", 32'(pslverr[1]), 32'd0);
        chk("rst prdata", prdata[1], 32'd0);
        chk("rst strobes", {30'd0, wr_stb[1], rd_stb[1]}, 32'd0);
        chk("rst stb_idx", 32'(stb_idx[1]), 32'd0);
        chk("rst reg2", regs_q[1][2*32 +: 32], 32'd0);
        psel[1] = 1'b0; penable[1] = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        @(posedge clk); #1;
        chk("rst no strobe", 32'(wr_cnt[1] - w0), 32'd0);
        do_txn("post-reset rd2", 1, 12'h008, 1'b0, 32'h0, 32'h0, 1'b0);
        do_txn("post-reset rd1", 0, 12'h004, 1'b0, 32'h0, 32'h0, 1'b0);

        // Back-to-back writes to every register, then readback
        w0 = wr_cnt[1];
        for (int i = 0; i < 8; i++)
            do_txn($sformatf("b2b wr%0d", i), 1, 12'(i * 4), 1'b1, $urandom, 32'h0, 1'b0);
        chk("b2b wr_stb total", 32'(wr_cnt[1] - w0), 32'd8);
        for (int i = 0; i < 8; i++)
            do_txn($sformatf("b2b rd%0d", i), 1, 12'(i * 4), 1'b0, 32'h0, mdl[1][i], 1'b0);

        // Randomised traffic against the reference model
        for (int n = 0; n < 80; n++) begin
            k = int'($urandom_range(0, 1));
            a = 12'($urandom_range(0, 11) * 4);
            if ($urandom_range(0, 7) == 0) a = a + 12'($urandom_range(1, 3));
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            model_exp(k, a, w, er, ee);
            do_txn($sformatf("rnd%0d", n), k, a, w, d, er, ee);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        for (int i = 0; i < 7; i++)
            chk($sformatf("final bank0 reg%0d", i), regs_q[0][i*32 +: 32], mdl[0][i]);
        for (int i = 0; i < 8; i++)
            chk($sformatf("final bank1 reg%0d", i), regs_q[1][i*32 +: 32], mdl[1][i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
